cpu_cycle_sequencer: RTL

Parametrised cycle sequencer for the 2A03 core: owns the per-instruction cycle counter that feeds the control ROM, the 7-cycle reset and interrupt sequences, NMI edge detection, IRQ masking, page-cross/branch cycle extension and RDY stalls. It sits between the decode/control ROM and the datapath in `cpu_2a03`. It replaces the bare fixed-width counter with a configurable one whose instruction end is supplied by decode.

---
 rtl/cpu_2a03_pkg.sv | 23 ++
 rtl/cpu_cycle_sequencer_nmi_edge_latch.sv | 30 +++
 rtl/cpu_cycle_sequencer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/cpu_2a03_pkg.sv
// Shared definitions for the 2A03 core: sequencer states, interrupt vector
// selects and the cycle-counter constants that index the control ROM.
package cpu_2a03_pkg;

    typedef enum logic [1:0] {
        RESET_SEQ = 2'd0,
        FETCH     = 2'd1,
        EXEC      = 2'd2,
        INT_SEQ   = 2'd3
    } seq_state_t;

    localparam logic [1:0] VEC_NONE  = 2'b00;
    localparam logic [1:0] VEC_NMI   = 2'b01;
    localparam logic [1:0] VEC_RESET = 2'b10;
    localparam logic [1:0] VEC_IRQ   = 2'b11;

    // Control ROM row for the opcode fetch, the first execute row, and the
    // shortest legal last-cycle index (every instruction takes at least 2 cycles).
    localparam int CYC_COUNT_FETCH      = 0;
    localparam int CYC_COUNT_FIRST_EXEC = 1;
    localparam int CYC_COUNT_MIN_LAST   = 1;

endpackage

// File: rtl/cpu_cycle_sequencer_nmi_edge_latch.sv
// NMI falling-edge detector with a set/clear pending latch; block suppresses
// new edges while an NMI sequence is already running.
module nmi_edge_latch (
    input  logic clock,
    input  logic nreset,
    input  logic nnmi,
    input  logic block,
    input  logic clear,
    output logic pending
);

    logic nnmi_q;
    logic latch_q;
    logic fall;

    assign fall    = nnmi_q & ~nnmi & ~block;
    assign pending = latch_q | fall;

    // nnmi idles high, so reset to 1 to avoid a false edge on release.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            nnmi_q  <= 1'b1;
            latch_q <= 1'b0;
        end else begin
            nnmi_q  <= nnmi;
            latch_q <= clear ? 1'b0 : (latch_q | fall);
        end
    end

endmodule

// File: rtl/cpu_cycle_sequencer.sv
// Per-instruction cycle sequencer for the 2A03 core (reset/interrupt sequences,
// cycle extension, NMI/IRQ arbitration). Define CPU_SEQ_RDY_EN to enable RDY read stalls.
module cpu_cycle_sequencer
    import cpu_2a03_pkg::*;
#(
    parameter int CYC_W      = 3,
    parameter int INT_CYCLES = 7
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic [CYC_W-1:0] op_cycles,
    input  logic             add_cycle,
    input  logic             nnmi,
    input  logic             nirq,
    input  logic             i_flag,
    input  logic             rw,
    input  logic             rdy,
    output logic [CYC_W-1:0] cyc_count,
    output logic             sync,
    output logic             inject_brk,
    output logic             force_read,
    output logic [1:0]       vector_sel
);

    localparam logic [CYC_W-1:0] MAX_CYC   = {CYC_W{1'b1}};
    localparam logic [CYC_W-1:0] INT_LAST  = CYC_W'(INT_CYCLES - 1);
    localparam logic [CYC_W-1:0] FETCH_CYC = CYC_W'(CYC_COUNT_FETCH);
    localparam logic [CYC_W-1:0] FIRST_CYC = CYC_W'(CYC_COUNT_FIRST_EXEC);
    localparam logic [CYC_W-1:0] MIN_LAST  = CYC_W'(CYC_COUNT_MIN_LAST);

    seq_state_t       state;
    seq_state_t       state_next;
    logic [CYC_W-1:0] cyc_next;
    logic [CYC_W-1:0] last_cyc;
    logic [CYC_W-1:0] last_next;
    logic [CYC_W-1:0] cur_last;
    logic [CYC_W-1:0] ext_last;
    logic [1:0]       vec_q;
    logic [1:0]       vec_next;
    logic             stall;
    logic             nmi_pending;
    logic             nmi_clear;
    logic             nmi_block;

`ifdef CPU_SEQ_RDY_EN
    assign stall = ~rdy & rw;
`else
    logic rdy_unused;
    assign rdy_unused = rdy & rw;
    assign stall      = 1'b0;
`endif

    assign nmi_block = (state == INT_SEQ) && (vec_q == VEC_NMI);

    nmi_edge_latch u_nmi_edge_latch (
        .clock   (clock),
        .nreset  (nreset),
        .nnmi    (nnmi),
        .block   (nmi_block),
        .clear   (nmi_clear),
        .pending (nmi_pending)
    );

    // Instruction end is loaded from decode on cycle 1; add_cycle on that
    // same edge extends the freshly loaded value rather than the stale one.
    always_comb begin
        cur_last = last_cyc;
        if (cyc_count == FIRST_CYC) begin
            cur_last = (op_cycles < MIN_LAST) ? MIN_LAST : op_cycles;
        end
        ext_last = cur_last;
        if (add_cycle && (cur_last != MAX_CYC)) begin
            ext_last = cur_last + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        cyc_next   = cyc_count;
        last_next  = last_cyc;
        vec_next   = vec_q;
        nmi_clear  = 1'b0;
        if (!stall) begin
            case (state)
                RESET_SEQ: begin
                    if (cyc_count == INT_LAST) begin
                        state_next = FETCH;
                        cyc_next   = FETCH_CYC;
                        vec_next   = VEC_NONE;
                    end else begin
                        cyc_next = cyc_count + 1'b1;
                    end
                end
                FETCH: begin
                    state_next = EXEC;
                    cyc_next   = FIRST_CYC;
                end
                EXEC: begin
                    last_next = ext_last;
                    if (cyc_count >= ext_last) begin
                        cyc_next = FETCH_CYC;
                        if (nmi_pending) begin
                            state_next = INT_SEQ;
                            vec_next   = VEC_NMI;
                            nmi_clear  = 1'b1;
                        end else if (!nirq && !i_flag) begin
                            state_next = INT_SEQ;
                            vec_next   = VEC_IRQ;
                        end else begin
                            state_next = FETCH;
                        end
                    end else begin
                        cyc_next = cyc_count + 1'b1;
                    end
                end
                INT_SEQ: begin
                    // An NMI arriving before the last IRQ cycle takes over its vector.
                    if ((vec_q == VEC_IRQ) && nmi_pending && (cyc_count != INT_LAST)) begin
                        vec_next  = VEC_NMI;
                        nmi_clear = 1'b1;
                    end
                    if (cyc_count == INT_LAST) begin
                        state_next = FETCH;
                        cyc_next   = FETCH_CYC;
                        vec_next   = VEC_NONE;
                    end else begin
                        cyc_next = cyc_count + 1'b1;
                    end
                end
                default: begin
                    state_next = RESET_SEQ;
                    cyc_next   = FETCH_CYC;
                    vec_next   = VEC_RESET;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state     <= RESET_SEQ;
            cyc_count <= FETCH_CYC;
            last_cyc  <= '0;
            vec_q     <= VEC_RESET;
        end else begin
            state     <= state_next;
            cyc_count <= cyc_next;
            last_cyc  <= last_next;
            vec_q     <= vec_next;
        end
    end

    // Cycle 0 of the reset sequence is the reset-held cycle, so BRK injection
    // starts once the counter has left zero.
    assign sync       = (state == FETCH) || ((state == INT_SEQ) && (cyc_count == FETCH_CYC));
    assign inject_brk = ((state == RESET_SEQ) && (cyc_count != FETCH_CYC)) ||
                        ((state == INT_SEQ) && (cyc_count == FETCH_CYC));
    assign force_read = (state == RESET_SEQ);
    assign vector_sel = vec_q;

endmodule
